// File: rtl/pll_pkg.sv
// Shared constants and types for the phase-locked square-wave generator.
// Slot geometry, lock tolerance and the lock FSM state encoding.
package pll_pkg;

  localparam int PHASE_W        = 5;
  localparam int N_SLOTS        = 32;
  localparam int SLOT_SHIFT     = $clog2(N_SLOTS);
  localparam int LOCK_TOL_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_UNSTARTED = 2'd0,
    ST_MEASURING = 2'd1,
    ST_LOCKED    = 2'd2
  } lock_st_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop; one-cycle pulse on rising edge.
// Reusable for any asynchronous level input sampled into clk.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/phase_shift_generator.sv
// Measures the reference period, tracks lock, and emits a 50% square
// wave delayed by phase_in thirty-seconds of a period from each edge.
module phase_shift_generator
  import pll_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 64,
  parameter int MAX_PERIOD = 2**24-1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_in,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               output_on,
  output logic               out,
  output logic               locked,
  output logic [CNT_W-1:0]   period
);

  localparam int PW = CNT_W + 1;
  localparam int WW = CNT_W + PHASE_W;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MAX_PERIOD - 1);
  localparam logic [PW-1:0]    P_MIN   = PW'(MIN_PERIOD);
  localparam logic [PW-1:0]    P_MAX   = PW'(MAX_PERIOD);

  logic               w_edge;
  logic [CNT_W-1:0]   r_cnt;
  lock_st_t           r_state;
  logic               r_prev_ok;
  logic [PHASE_W-1:0] r_phase;
  logic               r_on;

  edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ref_in),
    .o_rise  (w_edge)
  );

  logic [PW-1:0] w_p;
  logic [PW-1:0] w_per_x;
  logic [PW-1:0] w_diff;
  logic [PW-1:0] w_tol;
  logic          w_p_ok;
  logic          w_match;
  logic          w_timeout;

  assign w_p     = {1'b0, r_cnt} + PW'(1);
  assign w_per_x = {1'b0, period};
  assign w_diff  = (w_p >= w_per_x) ? (w_p - w_per_x)
                                    : (w_per_x - w_p);
  assign w_tol   = w_per_x >> LOCK_TOL_SHIFT;
  assign w_p_ok  = (w_p >= P_MIN) && (w_p <= P_MAX);
  assign w_match = (w_diff <= w_tol);

  // Timeout fires as cnt steps onto MAX; an edge that cycle wins.
  assign w_timeout = !w_edge && (r_cnt >= CNT_TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_state   <= ST_UNSTARTED;
      r_prev_ok <= 1'b0;
      r_phase   <= '0;
      r_on      <= 1'b0;
      locked    <= 1'b0;
      period    <= '0;
    end else if (w_edge) begin
      r_cnt   <= '0;
      r_phase <= phase_in;
      r_on    <= output_on;
      unique case (r_state)
        ST_UNSTARTED: begin
          r_state <= ST_MEASURING;
        end
        ST_MEASURING, ST_LOCKED: begin
          if (w_p_ok)
            period <= w_p[CNT_W-1:0];
          r_prev_ok <= w_p_ok;
          if (w_p_ok && w_match && r_prev_ok) begin
            r_state <= ST_LOCKED;
            locked  <= 1'b1;
          end else begin
            r_state <= ST_MEASURING;
            locked  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_UNSTARTED;
          locked  <= 1'b0;
        end
      endcase
    end else begin
      if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) begin
        r_state   <= ST_UNSTARTED;
        r_prev_ok <= 1'b0;
        locked    <= 1'b0;
      end
    end
  end

  logic [WW-1:0] w_per_w;
  logic [WW-1:0] w_cnt_w;
  logic [WW-1:0] w_slot;
  logic [WW-1:0] w_delay;
  logic [WW-1:0] w_half;
  logic [WW-1:0] w_end;
  logic          w_win;

  assign w_per_w = WW'(period);
  assign w_cnt_w = WW'(r_cnt);
  assign w_slot  = w_per_w >> SLOT_SHIFT;
  assign w_delay = w_slot * WW'(r_phase);
  assign w_half  = w_per_w >> 1;
  assign w_end   = w_delay + w_half;

  // Late phases spill the high half over the next reference edge.
  assign w_win = (w_end < w_per_w)
    ? ((w_cnt_w >= w_delay) && (w_cnt_w < w_end))
    : ((w_cnt_w >= w_delay) ||
       (w_cnt_w < (w_end - w_per_w)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out <= 1'b0;
    else
      out <= w_win & locked & r_on & output_on;
  end

endmodule

// File: doc/phase_shift_generator.md
# phase_shift_generator

Downstream stage of the phase controller: consumes its 5-bit phase index and output-enable and produces the physical phase-shifted square wave. Measures the period of an external reference square wave in `clk` cycles, divides it into 32 equal slots, and drives a 50%-duty output delayed by `phase_in` slots from each reference rising edge. Also reports measured period and a lock flag for status LEDs and arming logic.

## Interface
- `CNT_W`, 24: width of the period counter and measured period.
- `MIN_PERIOD`, 64: smallest valid reference period, in `clk` cycles.
- `MAX_PERIOD`, 2**24-1: largest valid period; no edge for longer is a timeout.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ref_in`  in  1  asynchronous reference square wave.
- `phase_in`  in  5  slot index, 0..31, from the phase controller.
- `output_on`  in  1  enable from the phase controller.
- `out`  out  1  registered phase-shifted output.
- `locked`  out  1  registered; period measurement stable.
- `period`  out  CNT_W  last measured period, in `clk` cycles.

## Operation
- All outputs and internal state reset to 0.
- `ref_in` passes through two synchronizer flops (s1, s2) and a third delay flop (s3). `edge` = s2 & ~s3.
- `cnt` counts `clk` cycles since the last edge and saturates at `MAX_PERIOD`.
  - On `edge`: `cnt` <= 0.
  - If a start reference exists: measured period p = cnt+1.
- `started` flag:
  - The first edge after reset or after a lock loss only sets `started`; no period is produced.
- Period validation on each edge with `started` = 1:
  - p is valid if MIN_PERIOD <= p <= MAX_PERIOD.
  - p matches if |p - period| <= period>>4.
  - If valid: `period` <= p.
  - `locked` <= 1 if p is valid and matches the previous period, and the previous period was also valid.
  - Otherwise `locked` <= 0.
  - With a steady reference, `locked` asserts at the 3rd edge after reset.
- Timeout: if `cnt` reaches `MAX_PERIOD` without an edge, then `locked` <= 0, `started` <= 0, and `period` holds its value.
- On each edge, `phase_lat` <= `phase_in` and `on_lat` <= `output_on`. Phase changes therefore take effect only at reference edges; no glitch mid-period.
- Window arithmetic uses the current `period`, held in CNT_W+5 bits:
  - slot = period>>5
  - delay = phase_lat*slot
  - half = period>>1
  - end = delay+half
- In-window rule:
  - If end < period: in-window is delay <= cnt < end.
  - Else (wrap-around): in-window is cnt >= delay or cnt < end-period.
- `out` <= in-window & `locked` & `on_lat` & `output_on`.
  - A falling `output_on` forces `out` low on the next cycle.
  - A rising `output_on` takes effect from the next edge.
- Simultaneous edge and timeout in the same cycle: the edge wins; p = MAX_PERIOD is valid.
- Reset mid-operation clears everything immediately (asynchronous). Re-lock requires 3 edges.

## Timing
- Let `ref_in` rise before `clk` edge E0. Then s1=1 after E0, `edge`=1 between E1 and E2, and `cnt`=0 after E2.
- Phase 0: `out` rises after E3, so ref-to-out latency is 3 cycles.
- Phase k: `out` rises after E3 + k*slot.
- `locked`, `period`, `phase_lat` and `on_lat` update at the same edge that zeroes `cnt`.
- The multiplier may be pipelined by at most 1 cycle. It is recomputed only when `period` or `phase_lat` changes, so its latency is hidden; `out` timing above is exact.
- Slot quantization is floor(period/32). Residual period mod 32 cycles are absorbed in the last slot.

## Structure
- Shared package `pll_pkg` holds:
  - PHASE_W = 5
  - N_SLOTS = 32
  - SLOT_SHIFT = 5
  - the lock-tolerance shift (4)
- Sub-module `edge_sync`: 2-flop synchronizer plus delay flop and rising-edge pulse. It takes `clk` and `rst_n` and is reusable for the controller's trigger and change-phase pins.
- Top level holds the counter, lock FSM (UNSTARTED, MEASURING, LOCKED) and window logic.

## Test plan
- Steady 320-cycle `ref_in`, `phase_in`=0, `output_on`=1 -> `locked`=1 at 3rd edge, `period`=320, `out` high 160 cycles starting 3 cycles after each `ref_in` rise.
- Same reference, `phase_in`=3 -> `out` rises 30 cycles later than for phase 0. Change to 20 mid-period -> takes effect only after the next edge (delay 200; window wraps, `out` high for cnt >= 200 or cnt < 40).
- Period jumps 320 -> 400 -> `locked` drops at that edge and `out` goes low. Steady 400 -> `locked` at the next edge, `period`=400. Jump 320 -> 330 (within tolerance 20) keeps `locked`.
- Reference stops with MAX_PERIOD=1000 -> `locked`=0 and `out`=0 when `cnt` reaches 1000. Restart -> lock after 3 edges.
- `ref_in` period 40 (< MIN_PERIOD) -> `locked` never asserts, `out` stays 0, `period` keeps its last valid value.
- `output_on` falls mid-window -> `out` low next cycle; rises mid-period -> `out` stays low until the next edge. `rst_n` low mid-window -> all outputs 0 immediately.
